// File: rtl/bitserial_mac_seq_if.sv
// Bundle of handshake and data signals between the activation/weight source,
// the bit-serial MAC sequencer and the MAC array.
//   w_start/w_valid/w_ready/w_data : weight-load handshake (one weight row per beat)
//   w_loaded                       : full weight matrix resident
//   a_valid/a_ready/a_data         : activation row handshake
//   mac_valid/mac_data1..4/mac_last: bit-plane stream towards the MAC array
//   busy                           : sequencer not idle
// The master modport is the source side; the slave modport is the sequencer.
interface bitserial_mac_seq_if #(
  parameter int N_K   = 32,
  parameter int N_COL = 4,
  parameter int DW    = 4
);
  logic                   w_start;
  logic                   w_valid;
  logic                   w_ready;
  logic [N_COL*DW-1:0]    w_data;
  logic                   w_loaded;
  logic                   a_valid;
  logic                   a_ready;
  logic [N_K*DW-1:0]      a_data;
  logic                   mac_valid;
  logic [N_K*DW-1:0]      mac_data1;
  logic [N_K*DW-1:0]      mac_data2;
  logic [N_K*DW-1:0]      mac_data3;
  logic [N_K*DW-1:0]      mac_data4;
  logic                   mac_last;
  logic                   busy;

  modport master (
    output w_start, w_valid, w_data, a_valid, a_data,
    input  w_ready, w_loaded, a_ready, mac_valid,
           mac_data1, mac_data2, mac_data3, mac_data4, mac_last, busy
  );

  modport slave (
    input  w_start, w_valid, w_data, a_valid, a_data,
    output w_ready, w_loaded, a_ready, mac_valid,
           mac_data1, mac_data2, mac_data3, mac_data4, mac_last, busy
  );
endinterface

// File: rtl/bitserial_mac_seq.sv
// Sequencer for a 4-column bit-serial MAC array. Holds an N_K x N_COL matrix
// of DW-bit weights and turns each accepted activation row into DW bit-planes,
// MSB first, one per cycle. Each plane is presented as AND-masked partial
// product words, one per column.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : bitserial_mac_seq_if.slave (weight load, activation row, MAC stream)
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting; w_start begins a load, a loaded matrix accepts rows
// LOAD_W | accepting weight beats k=0..N_K-1 (w_ready=1)
// RUN    | streaming bit-planes of the latched row, bp = plane shown
module bitserial_mac_seq #(
  parameter int N_K   = 32,
  parameter int N_COL = 4,
  parameter int DW    = 4
) (
  input  logic                clk,
  input  logic                rst,
  bitserial_mac_seq_if.slave  bus
);

  localparam int CNT_W = $clog2(N_K);
  localparam int BP_W  = (DW > 1) ? $clog2(DW) : 1;
  localparam logic [BP_W-1:0]  BP_MSB   = BP_W'(DW - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_K - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOAD_W = 2'd1;
  localparam logic [1:0] S_RUN    = 2'd2;

  logic [1:0]            state;
  logic [CNT_W-1:0]      cnt;
  logic [BP_W-1:0]       bp;
  logic [N_K*DW-1:0]     act;
  logic [N_COL*DW-1:0]   w_mem [N_K];

  logic                  w_loaded_q;
  logic                  mac_valid_q;
  logic                  mac_last_q;
  logic [N_K*DW-1:0]     mac_q [N_COL];

  logic                  a_ready_c;
  logic                  accept;
  logic                  advance;
  logic [N_K*DW-1:0]     plane_row;
  logic [BP_W-1:0]       plane_bp;
  logic [N_K*DW-1:0]     plane_word [N_COL];

  // w_start wins over a pending row in IDLE; in RUN a new row may only enter
  // on the last plane so the stream stays gap-free.
  assign a_ready_c = w_loaded_q && !bus.w_start &&
                     ((state == S_IDLE) || ((state == S_RUN) && (bp == '0)));
  assign accept    = bus.a_valid && a_ready_c;
  assign advance   = (state == S_RUN) && (bp != '0);

  // Next plane to present: MSB of a freshly accepted row, else the next lower
  // plane of the current row. Outputs are registered from this.
  always_comb begin
    plane_row = accept ? bus.a_data : act;
    plane_bp  = accept ? BP_MSB : (bp - 1'b1);
    for (int c = 0; c < N_COL; c++) begin
      plane_word[c] = '0;
      for (int k = 0; k < N_K; k++) begin
        plane_word[c][k*DW +: DW] = {DW{plane_row[k*DW + int'(plane_bp)]}} &
                                    w_mem[k][c*DW +: DW];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      bp          <= '0;
      w_loaded_q  <= 1'b0;
      mac_valid_q <= 1'b0;
      mac_last_q  <= 1'b0;
      for (int c = 0; c < N_COL; c++) mac_q[c] <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.w_start) begin
            state      <= S_LOAD_W;
            w_loaded_q <= 1'b0;
            cnt        <= '0;
          end else if (accept) begin
            state <= S_RUN;
          end
        end
        S_LOAD_W: begin
          if (bus.w_valid) begin
            cnt <= cnt + 1'b1;
            if (cnt == CNT_LAST) begin
              state      <= S_IDLE;
              w_loaded_q <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if ((bp == '0) && !accept) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase

      if (accept)       bp <= BP_MSB;
      else if (advance) bp <= bp - 1'b1;

      if (accept || advance) begin
        mac_valid_q <= 1'b1;
        mac_last_q  <= (plane_bp == '0);
        for (int c = 0; c < N_COL; c++) mac_q[c] <= plane_word[c];
      end else begin
        mac_valid_q <= 1'b0;
        mac_last_q  <= 1'b0;
        for (int c = 0; c < N_COL; c++) mac_q[c] <= '0;
      end
    end
  end

  // Weight buffer and activation latch are data-path only; no reset needed.
  always_ff @(posedge clk) begin
    if ((state == S_LOAD_W) && bus.w_valid) w_mem[cnt] <= bus.w_data;
    if (accept) act <= bus.a_data;
  end

  assign bus.w_ready   = (state == S_LOAD_W);
  assign bus.w_loaded  = w_loaded_q;
  assign bus.a_ready   = a_ready_c;
  assign bus.mac_valid = mac_valid_q;
  assign bus.mac_last  = mac_last_q;
  assign bus.mac_data1 = mac_q[0];
  assign bus.mac_data2 = mac_q[1];
  assign bus.mac_data3 = mac_q[2];
  assign bus.mac_data4 = mac_q[3];
  assign bus.busy      = (state != S_IDLE);

endmodule
